console_sequencer: RTL and testbench

CONSOLE_SEQUENCER -- requirements
Module: console_sequencer

---
 rtl/console_sequencer_pkg.sv | 39 +++
 rtl/console_sequencer_disp_mux.sv | 47 ++++
 rtl/console_sequencer.sv | 208 ++++++++++++++++++++
 tb/tb_console_sequencer.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/console_sequencer_pkg.sv
// rtl/console_sequencer_pkg.sv - shared CPU definitions for the front-panel console sequencer
//
// Contents:
//   word_t      12-bit machine word
//   dispsel_t   display source encodings (00=PC, 01=AC, 10=MA, 11=MB)
//   state_t     console sequencer FSM states
//   word_inc    12-bit wrapping increment
// Macro CONSOLE_DEPOSIT_AUTOINC_EN adds the DEP_INC state.
package console_sequencer_pkg;

    typedef logic [11:0] word_t;

    typedef enum logic [1:0] {
        DISP_PC = 2'b00,
        DISP_AC = 2'b01,
        DISP_MA = 2'b10,
        DISP_MB = 2'b11
    } dispsel_t;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        LDPC      = 4'd1,
        LDAC      = 4'd2,
        DEP_REQ   = 4'd3,
`ifdef CONSOLE_DEPOSIT_AUTOINC_EN
        DEP_INC   = 4'd4,
`endif
        STEP_GO   = 4'd5,
        STEP_WAIT = 4'd6,
        RUN_GO    = 4'd7,
        RUN_WAIT  = 4'd8
    } state_t;

    // 7777 + 1 wraps to 0000 through the 12-bit result width.
    function automatic word_t word_inc(input word_t w);
        return w + 12'd1;
    endfunction

endpackage

// File: rtl/console_sequencer_disp_mux.sv
// rtl/console_sequencer_disp_mux.sv - registered display source selector
//
// Module console_disp_mux
//   clock, resetN     clock and asynchronous active-low reset
//   dispsel           source select (see dispsel_t)
//   pc_in..mb_in      CPU register values
//   link_in           CPU link bit
//   dispout, linkout  selected value and link, one cycle latency
module console_disp_mux
    import console_sequencer_pkg::*;
(
    input  logic        clock,
    input  logic        resetN,
    input  logic [1:0]  dispsel,
    input  logic [11:0] pc_in,
    input  logic [11:0] ac_in,
    input  logic [11:0] ma_in,
    input  logic [11:0] mb_in,
    input  logic        link_in,
    output logic [11:0] dispout,
    output logic        linkout
);

    word_t sel_word;

    always_comb begin
        sel_word = pc_in;
        case (dispsel_t'(dispsel))
            DISP_PC: sel_word = pc_in;
            DISP_AC: sel_word = ac_in;
            DISP_MA: sel_word = ma_in;
            DISP_MB: sel_word = mb_in;
            default: sel_word = pc_in;
        endcase
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            dispout <= '0;
            linkout <= 1'b0;
        end else begin
            dispout <= sel_word;
            linkout <= link_in;
        end
    end

endmodule

// File: rtl/console_sequencer.sv
// rtl/console_sequencer.sv - front-panel console sequencer (load, deposit, step, run)
//
// Module console_sequencer #(TIMEOUT)
//   clock, resetN                  clock and asynchronous active-low reset
//   loadpc/loadac/deposit/step     one-cycle panel command pulses
//   run                            continuous-execution level
//   swreg, dispsel                 switch register, display select
//   dispout, linkout               registered display outputs
//   halt                           one-cycle pulse clearing run upstream
//   ld_data, pc_ld, ac_ld          CPU register load path
//   mem_req/mem_addr/mem_wdata/mem_ack  deposit write handshake
//   go, done, hlt_instr            instruction execute handshake
//   pc_in/ac_in/ma_in/mb_in/link_in     CPU register values
//   busy, err                      not-idle flag, sticky timeout flag
// Macro CONSOLE_DEPOSIT_AUTOINC_EN: deposit increments PC afterwards.
module console_sequencer
    import console_sequencer_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        resetN,
    input  logic        loadpc,
    input  logic        loadac,
    input  logic        deposit,
    input  logic        step,
    input  logic        run,
    input  logic [11:0] swreg,
    input  logic [1:0]  dispsel,
    output logic [11:0] dispout,
    output logic        linkout,
    output logic        halt,
    output logic [11:0] ld_data,
    output logic        pc_ld,
    output logic        ac_ld,
    output logic        mem_req,
    output logic [11:0] mem_addr,
    output logic [11:0] mem_wdata,
    input  logic        mem_ack,
    output logic        go,
    input  logic        done,
    input  logic        hlt_instr,
    input  logic [11:0] pc_in,
    input  logic [11:0] ac_in,
    input  logic [11:0] ma_in,
    input  logic [11:0] mb_in,
    input  logic        link_in,
    output logic        busy,
    output logic        err
);

    // Abort on the last allowed waiting cycle so exactly TIMEOUT cycles are waited.
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

    state_t      state, state_next;
    word_t       latch;
    word_t       dep_addr;
    logic [15:0] wait_cnt;
    logic        cmd_accept;
    logic        timeout;
    logic        waiting;
    logic        cnt_last;

    assign waiting  = (state == DEP_REQ) || (state == STEP_WAIT) || (state == RUN_WAIT);
    assign cnt_last = (wait_cnt == TIMEOUT_LAST);
    assign busy     = (state != IDLE);

    always_comb begin
        state_next = state;
        cmd_accept = 1'b0;
        timeout    = 1'b0;
        pc_ld      = 1'b0;
        ac_ld      = 1'b0;
        ld_data    = '0;
        mem_req    = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        go         = 1'b0;
        halt       = 1'b0;
        case (state)
            IDLE: begin
                // run has precedence; panel pulses while running are dropped.
                if (run) begin
                    state_next = RUN_GO;
                end else if (loadpc) begin
                    state_next = LDPC;
                    cmd_accept = 1'b1;
                end else if (loadac) begin
                    state_next = LDAC;
                    cmd_accept = 1'b1;
                end else if (deposit) begin
                    state_next = DEP_REQ;
                    cmd_accept = 1'b1;
                end else if (step) begin
                    state_next = STEP_GO;
                    cmd_accept = 1'b1;
                end
            end
            LDPC: begin
                pc_ld      = 1'b1;
                ld_data    = latch;
                state_next = IDLE;
            end
            LDAC: begin
                ac_ld      = 1'b1;
                ld_data    = latch;
                state_next = IDLE;
            end
            DEP_REQ: begin
                mem_req   = 1'b1;
                mem_addr  = dep_addr;
                mem_wdata = latch;
                if (mem_ack) begin
`ifdef CONSOLE_DEPOSIT_AUTOINC_EN
                    state_next = DEP_INC;
`else
                    state_next = IDLE;
`endif
                end else if (cnt_last) begin
                    timeout    = 1'b1;
                    state_next = IDLE;
                end
            end
`ifdef CONSOLE_DEPOSIT_AUTOINC_EN
            DEP_INC: begin
                pc_ld      = 1'b1;
                ld_data    = word_inc(dep_addr);
                state_next = IDLE;
            end
`endif
            STEP_GO: begin
                go         = 1'b1;
                state_next = STEP_WAIT;
            end
            STEP_WAIT: begin
                if (done) begin
                    state_next = IDLE;
                end else if (cnt_last) begin
                    timeout    = 1'b1;
                    state_next = IDLE;
                end
            end
            RUN_GO: begin
                go         = 1'b1;
                state_next = RUN_WAIT;
            end
            RUN_WAIT: begin
                if (done) begin
                    if (hlt_instr) begin
                        halt       = 1'b1;
                        state_next = IDLE;
                    end else if (run) begin
                        state_next = RUN_GO;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (cnt_last) begin
                    timeout    = 1'b1;
                    halt       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state    <= IDLE;
            latch    <= '0;
            dep_addr <= '0;
            wait_cnt <= '0;
            err      <= 1'b0;
        end else begin
            state <= state_next;
            if (cmd_accept) begin
                latch    <= swreg;
                dep_addr <= pc_in;
            end
            // Wait states are never entered directly from another wait state,
            // so holding the counter at zero outside them clears it on entry.
            if (waiting) begin
                wait_cnt <= wait_cnt + 16'd1;
            end else begin
                wait_cnt <= '0;
            end
            if (timeout) begin
                err <= 1'b1;
            end else if (cmd_accept) begin
                err <= 1'b0;
            end
        end
    end

    console_disp_mux u_disp (
        .clock   (clock),
        .resetN  (resetN),
        .dispsel (dispsel),
        .pc_in   (pc_in),
        .ac_in   (ac_in),
        .ma_in   (ma_in),
        .mb_in   (mb_in),
        .link_in (link_in),
        .dispout (dispout),
        .linkout (linkout)
    );

endmodule

// File: tb/tb_console_sequencer.sv
// tb/tb_console_sequencer.sv - self-checking bench for console_sequencer
module tb_console_sequencer;

    logic        clock = 1'b0;
    logic        resetN = 1'b0;
    logic        loadpc = 1'b0, loadac = 1'b0, deposit = 1'b0, step = 1'b0, run = 1'b0;
    logic [11:0] swreg = '0;
    logic [1:0]  dispsel = '0;
    logic [11:0] dispout;
    logic        linkout, halt, pc_ld, ac_ld, mem_req, go, busy, err;
    logic [11:0] ld_data, mem_addr, mem_wdata;
    logic        mem_ack = 1'b0, done = 1'b0, hlt_instr = 1'b0, link_in = 1'b0;
    logic [11:0] pc_in = '0, ac_in = '0, ma_in = '0, mb_in = '0;

    int checks = 0;
    int failures = 0;
    logic [11:0] exp_q[$];
    logic [11:0] exp_v;

    always #5 clock = ~clock;

    console_sequencer #(.TIMEOUT(8)) dut (
        .clock(clock), .resetN(resetN),
        .loadpc(loadpc), .loadac(loadac), .deposit(deposit), .step(step), .run(run),
        .swreg(swreg), .dispsel(dispsel), .dispout(dispout), .linkout(linkout),
        .halt(halt), .ld_data(ld_data), .pc_ld(pc_ld), .ac_ld(ac_ld),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .go(go), .done(done), .hlt_instr(hlt_instr),
        .pc_in(pc_in), .ac_in(ac_in), .ma_in(ma_in), .mb_in(mb_in), .link_in(link_in),
        .busy(busy), .err(err)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        pc_in = 12'o1111;
        link_in = 1'b1;
        tick();
        tick();
        checks++;
        if ({busy, pc_ld, ac_ld, mem_req, go, halt, err} !== 7'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got %b expected 0000000", {busy, pc_ld, ac_ld, mem_req, go, halt, err});
        end
        checks++;
        if ({ld_data, mem_addr, mem_wdata} !== 36'b0) begin
            failures++;
            $display("FAIL reset_data: got %o %o %o expected 0 0 0", ld_data, mem_addr, mem_wdata);
        end
        checks++;
        if ({dispout, linkout} !== 13'b0) begin
            failures++;
            $display("FAIL reset_disp: got %o %b expected 0 0", dispout, linkout);
        end
        link_in = 1'b0;
        @(negedge clock);
        resetN = 1'b1;
        tick();
    endtask

    task automatic test_loadpc();
        swreg = 12'o0200;
        loadpc = 1'b1;
        exp_q.push_back(12'o0200);
        tick();
        loadpc = 1'b0;
        swreg = 12'o7777;
        exp_v = exp_q.pop_front();
        checks++;
        if (pc_ld !== 1'b1 || ac_ld !== 1'b0 || ld_data !== exp_v) begin
            failures++;
            $display("FAIL loadpc_strobe: got pc_ld=%b ac_ld=%b ld_data=%o expected 1 0 %o", pc_ld, ac_ld, ld_data, exp_v);
        end
        tick();
        checks++;
        if (pc_ld !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL loadpc_end: got pc_ld=%b busy=%b expected 0 0", pc_ld, busy);
        end
    endtask

    task automatic test_deposit();
        int held;
        logic bad;
        held = 0;
        bad = 1'b0;
        pc_in = 12'o7777;
        swreg = 12'o1234;
        deposit = 1'b1;
        exp_q.push_back(12'o7777);
        exp_q.push_back(12'o1234);
        exp_q.push_back(12'o0000);
        tick();
        deposit = 1'b0;
        pc_in = 12'o0001;
        swreg = 12'o0000;
        exp_v = exp_q.pop_front();
        for (int i = 0; i < 3; i++) begin
            if (mem_req === 1'b1) held++;
            if (mem_addr !== exp_v || mem_wdata !== exp_q[0] || pc_ld !== 1'b0) bad = 1'b1;
            if (i == 2) mem_ack = 1'b1;
            tick();
            mem_ack = 1'b0;
        end
        void'(exp_q.pop_front());
        checks++;
        if (held != 3) begin
            failures++;
            $display("FAIL deposit_req_cycles: got %0d expected 3", held);
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL deposit_addr_data: got addr=%o wdata=%o expected %o 1234", mem_addr, mem_wdata, exp_v);
        end
        exp_v = exp_q.pop_front();
`ifdef CONSOLE_DEPOSIT_AUTOINC_EN
        checks++;
        if (pc_ld !== 1'b1 || ld_data !== exp_v || mem_req !== 1'b0) begin
            failures++;
            $display("FAIL deposit_inc: got pc_ld=%b ld_data=%o mem_req=%b expected 1 %o 0", pc_ld, ld_data, mem_req, exp_v);
        end
        tick();
`endif
        checks++;
        if (pc_ld !== 1'b0 || busy !== 1'b0 || mem_req !== 1'b0) begin
            failures++;
            $display("FAIL deposit_end: got pc_ld=%b busy=%b mem_req=%b expected 0 0 0", pc_ld, busy, mem_req);
        end
    endtask

    task automatic test_priority();
        int ac_cnt, go_cnt, pc_cnt;
        logic bad;
        ac_cnt = 0; go_cnt = 0; pc_cnt = 0; bad = 1'b0;
        swreg = 12'o0055;
        loadac = 1'b1;
        step = 1'b1;
        exp_q.push_back(12'o0055);
        tick();
        loadac = 1'b0;
        step = 1'b0;
        exp_v = exp_q.pop_front();
        for (int i = 0; i < 6; i++) begin
            if (ac_ld) begin
                ac_cnt++;
                if (ld_data !== exp_v) bad = 1'b1;
            end
            if (go) go_cnt++;
            if (pc_ld) pc_cnt++;
            tick();
        end
        checks++;
        if (ac_cnt != 1 || go_cnt != 0 || pc_cnt != 0 || bad) begin
            failures++;
            $display("FAIL priority: got ac_ld=%0d go=%0d pc_ld=%0d bad=%b expected 1 0 0 0", ac_cnt, go_cnt, pc_cnt, bad);
        end
        // Stray handshakes in IDLE must not start anything.
        done = 1'b1;
        mem_ack = 1'b1;
        tick();
        done = 1'b0;
        mem_ack = 1'b0;
        checks++;
        if (busy !== 1'b0 || go !== 1'b0 || pc_ld !== 1'b0) begin
            failures++;
            $display("FAIL stray_ack: got busy=%b go=%b pc_ld=%b expected 0 0 0", busy, go, pc_ld);
        end
    endtask

    task automatic test_run();
        int go_cnt, halt_cnt, done_at;
        logic [11:0] h;
        go_cnt = 0; halt_cnt = 0; done_at = -1;
        run = 1'b1;
        for (int c = 0; c < 30; c++) begin
            tick();
            done = 1'b0;
            hlt_instr = 1'b0;
            if (go) begin
                go_cnt++;
                exp_q.push_back((go_cnt == 3) ? 12'd1 : 12'd0);
                done_at = c + 2;
            end
            if (c == done_at && exp_q.size() > 0) begin
                h = exp_q.pop_front();
                done = 1'b1;
                hlt_instr = h[0];
            end
            #1;
            if (halt) begin
                halt_cnt++;
                run = 1'b0;
            end
        end
        done = 1'b0;
        hlt_instr = 1'b0;
        run = 1'b0;
        checks++;
        if (go_cnt != 3 || halt_cnt != 1) begin
            failures++;
            $display("FAIL run_pulses: got go=%0d halt=%0d expected 3 1", go_cnt, halt_cnt);
        end
        checks++;
        if (busy !== 1'b0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL run_end: got busy=%b pending=%0d expected 0 0", busy, exp_q.size());
        end
    endtask

    task automatic test_run_drop();
        int go_cnt;
        go_cnt = 0;
        run = 1'b1;
        tick();
        checks++;
        if (go !== 1'b1) begin
            failures++;
            $display("FAIL run_drop_go: got %b expected 1", go);
        end
        run = 1'b0;
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (go) go_cnt++;
            tick();
        end
        checks++;
        if (go_cnt != 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL run_drop_end: got go=%0d busy=%b expected 0 0", go_cnt, busy);
        end
    endtask

    task automatic test_timeout();
        int n;
        logic halt_seen;
        n = 0;
        halt_seen = 1'b0;
        step = 1'b1;
        tick();
        step = 1'b0;
        checks++;
        if (go !== 1'b1) begin
            failures++;
            $display("FAIL step_go: got %b expected 1", go);
        end
        for (int i = 0; i < 40; i++) begin
            tick();
            n++;
            if (halt) halt_seen = 1'b1;
            if (err) break;
        end
        checks++;
        if (n - 1 != 8 || err !== 1'b1) begin
            failures++;
            $display("FAIL timeout_cycles: got waited=%0d err=%b expected 8 1", n - 1, err);
        end
        checks++;
        if (halt_seen || busy !== 1'b0) begin
            failures++;
            $display("FAIL timeout_nohalt: got halt=%b busy=%b expected 0 0", halt_seen, busy);
        end
        swreg = 12'o0000;
        loadpc = 1'b1;
        tick();
        loadpc = 1'b0;
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL err_clear: got %b expected 0", err);
        end
        tick();
    endtask

    task automatic test_disp();
        pc_in = 12'd1;
        ac_in = 12'd2;
        ma_in = 12'd3;
        mb_in = 12'd4;
        for (int s = 0; s < 4; s++) begin
            dispsel = 2'(s);
            exp_q.push_back(12'(s + 1));
            tick();
            exp_v = exp_q.pop_front();
            checks++;
            if (dispout !== exp_v) begin
                failures++;
                $display("FAIL dispout_sel%0d: got %0d expected %0d", s, dispout, exp_v);
            end
        end
        link_in = 1'b1;
        tick();
        checks++;
        if (linkout !== 1'b1) begin
            failures++;
            $display("FAIL linkout: got %b expected 1", linkout);
        end
        link_in = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic bad;
        bad = 1'b0;
        pc_in = 12'o0100;
        deposit = 1'b1;
        tick();
        deposit = 1'b0;
        checks++;
        if (mem_req !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_req: got %b expected 1", mem_req);
        end
        #2;
        resetN = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_abort: got mem_req=%b busy=%b expected 0 0", mem_req, busy);
        end
        @(negedge clock);
        resetN = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (pc_ld || mem_req || go || halt || busy) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL reset_mid_trail: got activity=%b expected 0", bad);
        end
    endtask

    task automatic test_run_after_reset();
        @(negedge clock);
        resetN = 1'b0;
        run = 1'b1;
        @(negedge clock);
        resetN = 1'b1;
        tick();
        checks++;
        if (go !== 1'b1) begin
            failures++;
            $display("FAIL run_after_reset: got go=%b expected 1", go);
        end
        run = 1'b0;
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL run_after_reset_end: got busy=%b expected 0", busy);
        end
    endtask

    initial begin
        test_reset();
        test_loadpc();
        test_deposit();
        test_priority();
        test_run();
        test_run_drop();
        test_timeout();
        test_disp();
        test_reset_mid();
        test_run_after_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got time limit expected finish");
        $fatal(1, "watchdog");
    end

endmodule
